// File: rtl/fu_branch_pipe_if.sv
// Issue, result and redirect signals of the branch functional unit.
// The slave modport is the unit's view; master is the issue/consumer side.
interface fu_branch_pipe_if #(
  parameter int WORD_W     = 16,
  parameter int PC_W       = 16,
  parameter int OP_W       = 16,
  parameter int ROB_IDX_W  = 4,
  parameter int PREG_IDX_W = 5
);
  logic                  in_v_i;
  logic                  in_ready_o;
  logic [OP_W-1:0]       opcode_i;
  logic [PC_W-1:0]       pc_i;
  logic [WORD_W-1:0]     operand1_i;
  logic [WORD_W-1:0]     operand2_i;
  logic [2:0]            cond_i;
  logic [3:0]            flags_i;
  logic                  pred_taken_i;
  logic [PC_W-1:0]       pred_target_i;
  logic [ROB_IDX_W-1:0]  rob_dest_i;
  logic [PREG_IDX_W-1:0] reg_dest_i;
  logic                  flush_i;

  logic                  out_v_o;
  logic                  out_ready_i;
  logic [ROB_IDX_W-1:0]  out_rob_dest_o;
  logic [PREG_IDX_W-1:0] out_reg_dest_o;
  logic                  out_reg_w_o;
  logic [WORD_W-1:0]     out_result_o;
  logic                  out_taken_o;
  logic [PC_W-1:0]       out_target_o;
  logic                  out_mispredict_o;

  logic                  redirect_v_o;
  logic [PC_W-1:0]       redirect_pc_o;

  modport master (
    output in_v_i, opcode_i, pc_i, operand1_i, operand2_i, cond_i, flags_i,
           pred_taken_i, pred_target_i, rob_dest_i, reg_dest_i, flush_i, out_ready_i,
    input  in_ready_o, out_v_o, out_rob_dest_o, out_reg_dest_o, out_reg_w_o,
           out_result_o, out_taken_o, out_target_o, out_mispredict_o,
           redirect_v_o, redirect_pc_o
  );

  modport slave (
    input  in_v_i, opcode_i, pc_i, operand1_i, operand2_i, cond_i, flags_i,
           pred_taken_i, pred_target_i, rob_dest_i, reg_dest_i, flush_i, out_ready_i,
    output in_ready_o, out_v_o, out_rob_dest_o, out_reg_dest_o, out_reg_w_o,
           out_result_o, out_taken_o, out_target_o, out_mispredict_o,
           redirect_v_o, redirect_pc_o
  );
endinterface

// File: rtl/fu_branch_pipe.sv
// Pipelined branch resolve unit: credit-gated issue, fixed-latency pipe, output FIFO, redirect pulse.
// Define FU_BRANCH_STATS_EN to add saturating branch / mispredict counters.

`ifndef WORD_SIZE_P
`define WORD_SIZE_P 16
`endif
`ifndef WIDTH_OP
`define WIDTH_OP 16
`endif
`ifndef ROB_ENTRY
`define ROB_ENTRY 16
`endif
`ifndef NUM_PHYS_REG
`define NUM_PHYS_REG 32
`endif
`ifndef BCC_OP
`define BCC_OP 16'h0011
`endif
`ifndef BL_OP
`define BL_OP 16'h0012
`endif

module fu_branch_pipe #(
  parameter int WORD_W     = `WORD_SIZE_P,
  parameter int PC_W       = `WIDTH_OP,
  parameter int ROB_IDX_W  = $clog2(`ROB_ENTRY),
  parameter int PREG_IDX_W = $clog2(`NUM_PHYS_REG),
  parameter int STAGES     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  fu_branch_pipe_if.slave bus
`ifdef FU_BRANCH_STATS_EN
  ,
  output logic [15:0] stat_branches_o,
  output logic [15:0] stat_mispredicts_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 3;
  localparam int EXT_W = (PC_W > WORD_W) ? PC_W : WORD_W;

  typedef struct packed {
    logic [ROB_IDX_W-1:0]  rob_dest;
    logic [PREG_IDX_W-1:0] reg_dest;
    logic                  reg_w;
    logic [WORD_W-1:0]     result;
    logic                  taken;
    logic [PC_W-1:0]       next_pc;
    logic                  mispredict;
  } entry_t;

  logic              cond_true;
  logic              taken;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   pc_plus1;
  logic [EXT_W-1:0]  offset_ext;
  entry_t            eval;

  logic [STAGES-1:0] stage_v;
  entry_t            stage_d [STAGES];
  logic              last_v;
  entry_t            last;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [SUM_W-1:0]  credits_used;
  logic              accept;
  logic              push;
  logic              pop;
  entry_t            head;

  logic              redirect_v;
  logic [PC_W-1:0]   redirect_pc;

  always_comb begin
    cond_true = 1'b1;
    case (bus.cond_i)
      3'd0: cond_true = bus.flags_i[2];
      3'd1: cond_true = !bus.flags_i[2];
      3'd2: cond_true = bus.flags_i[3] ^ bus.flags_i[0];
      3'd3: cond_true = !(bus.flags_i[3] ^ bus.flags_i[0]);
      3'd4: cond_true = bus.flags_i[1];
      3'd5: cond_true = !bus.flags_i[1];
      3'd6: cond_true = bus.flags_i[3];
      default: cond_true = 1'b1;
    endcase
  end

  // Whole resolution happens on the issue inputs; the stages only delay the finished entry.
  always_comb begin
    pc_plus1      = bus.pc_i + PC_W'(1);
    offset_ext    = EXT_W'($signed(bus.operand2_i));
    taken         = 1'b1;
    target        = PC_W'(bus.operand1_i);
    eval          = '0;
    eval.rob_dest = bus.rob_dest_i;
    eval.reg_dest = bus.reg_dest_i;
    if (bus.opcode_i == `BCC_OP) begin
      taken  = cond_true;
      target = bus.pc_i + offset_ext[PC_W-1:0];
    end else if (bus.opcode_i == `BL_OP) begin
      eval.reg_w  = 1'b1;
      eval.result = WORD_W'(pc_plus1);
    end
    eval.taken      = taken;
    eval.next_pc    = taken ? target : pc_plus1;
    eval.mispredict = (taken != bus.pred_taken_i) ||
                      (taken && (target != bus.pred_target_i));
  end

  // Credits count both queued and in-flight entries, so the final stage always finds room.
  assign credits_used   = SUM_W'(fifo_count) + SUM_W'($countones(stage_v));
  assign bus.in_ready_o = credits_used < SUM_W'(FIFO_DEPTH);
  assign accept         = bus.in_v_i && bus.in_ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stage_v <= '0;
    end else if (bus.flush_i) begin
      stage_v <= '0;
    end else begin
      stage_v[0] <= accept;
      for (int i = 1; i < STAGES; i++) stage_v[i] <= stage_v[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    stage_d[0] <= eval;
    for (int i = 1; i < STAGES; i++) stage_d[i] <= stage_d[i-1];
  end

  assign last_v = stage_v[STAGES-1];
  assign last   = stage_d[STAGES-1];
  assign push   = last_v && !bus.flush_i;
  assign pop    = bus.out_v_o && bus.out_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= last;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (bus.flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head                 = fifo_mem[rd_ptr];
  assign bus.out_v_o          = fifo_count != '0;
  assign bus.out_rob_dest_o   = head.rob_dest;
  assign bus.out_reg_dest_o   = head.reg_dest;
  assign bus.out_reg_w_o      = head.reg_w;
  assign bus.out_result_o     = head.result;
  assign bus.out_taken_o      = head.taken;
  assign bus.out_target_o     = head.next_pc;
  assign bus.out_mispredict_o = head.mispredict;

  // Redirect leaves together with the FIFO push so fetch sees it as the entry lands.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      redirect_v  <= 1'b0;
      redirect_pc <= '0;
    end else if (bus.flush_i) begin
      redirect_v  <= 1'b0;
    end else begin
      redirect_v <= last_v && last.mispredict;
      if (last_v && last.mispredict) redirect_pc <= last.next_pc;
    end
  end

  assign bus.redirect_v_o  = redirect_v;
  assign bus.redirect_pc_o = redirect_pc;

`ifdef FU_BRANCH_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_branches_o    <= '0;
      stat_mispredicts_o <= '0;
    end else if (push) begin
      if (stat_branches_o != 16'hFFFF) stat_branches_o <= stat_branches_o + 16'd1;
      if (last.mispredict && (stat_mispredicts_o != 16'hFFFF))
        stat_mispredicts_o <= stat_mispredicts_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Self-checking bench for fu_branch_pipe: directed cases plus randomized traffic
// compared against a queue-based model of the unit's architectural behaviour.

`ifndef BCC_OP
`define BCC_OP 16'h0011
`endif
`ifndef BL_OP
`define BL_OP 16'h0012
`endif

module tb_fu_branch_pipe;

  localparam int STAGES     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam logic [15:0] OP_BCC = `BCC_OP;
  localparam logic [15:0] OP_BL  = `BL_OP;
  localparam logic [15:0] OP_JR  = 16'h0005;

  logic clk_i;
  logic reset_i;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  fu_branch_pipe_if #(.WORD_W(16), .PC_W(16), .OP_W(16), .ROB_IDX_W(4), .PREG_IDX_W(5)) bus ();

  fu_branch_pipe #(.STAGES(STAGES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    int          due;
    logic [3:0]  rob;
    logic [4:0]  rd;
    logic        reg_w;
    logic [15:0] result;
    logic        taken;
    logic [15:0] npc;
    logic        misp;
  } exp_t;

  // Model state: every accepted op waits here until it is popped; it becomes visible at its due cycle.
  exp_t        exp_q [$];
  int          redir_due [$];
  logic [15:0] redir_pc [$];
  int          cyc;
  int          checks;
  int          errors;

  logic        exp_in_ready;
  logic        exp_out_v;
  exp_t        exp_head;
  logic        exp_redir_v;
  logic [15:0] exp_redir_pc;

  function automatic exp_t predict(logic [15:0] op, logic [15:0] pc, logic [15:0] a,
                                   logic [15:0] b, logic [2:0] cond, logic [3:0] fl,
                                   logic pt, logic [15:0] ptgt, logic [3:0] rob, logic [4:0] rd);
    exp_t e;
    logic ok;
    int   tgt;
    int   seq;
    case (cond)
      3'd0: ok = fl[2];
      3'd1: ok = !fl[2];
      3'd2: ok = (fl[3] != fl[0]);
      3'd3: ok = (fl[3] == fl[0]);
      3'd4: ok = fl[1];
      3'd5: ok = !fl[1];
      3'd6: ok = fl[3];
      default: ok = 1'b1;
    endcase
    seq      = (int'(pc) + 1) % 65536;
    e.due    = 0;
    e.rob    = rob;
    e.rd     = rd;
    e.reg_w  = 1'b0;
    e.result = 16'h0000;
    e.taken  = 1'b1;
    tgt      = int'(a);
    if (op == OP_BCC) begin
      e.taken = ok;
      tgt     = (int'(pc) + int'($signed(b)) + 65536) % 65536;
    end else if (op == OP_BL) begin
      e.reg_w  = 1'b1;
      e.result = 16'(seq);
    end
    e.npc  = e.taken ? 16'(tgt) : 16'(seq);
    e.misp = (e.taken != pt) || (e.taken && (16'(tgt) != ptgt));
    return e;
  endfunction

  function automatic void compute_exp();
    exp_in_ready = (exp_q.size() < FIFO_DEPTH);
    exp_out_v    = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    if (exp_out_v) exp_head = exp_q[0];
    exp_redir_v  = (redir_due.size() > 0) && (redir_due[0] == cyc);
    exp_redir_pc = exp_redir_v ? redir_pc[0] : 16'h0000;
  endfunction

  // Advance one cycle: update the model from the inputs being presented, then clock.
  task automatic tick();
    exp_t e;
    logic acc;
    logic pop;
    compute_exp();
    acc = bus.in_v_i && exp_in_ready;
    pop = bus.out_ready_i && exp_out_v;
    while (redir_due.size() > 0 && redir_due[0] <= cyc) begin
      redir_due.delete(0);
      redir_pc.delete(0);
    end
    if (bus.flush_i) begin
      exp_q.delete();
      redir_due.delete();
      redir_pc.delete();
    end else begin
      if (pop) exp_q.delete(0);
      if (acc) begin
        e = predict(bus.opcode_i, bus.pc_i, bus.operand1_i, bus.operand2_i, bus.cond_i,
                    bus.flags_i, bus.pred_taken_i, bus.pred_target_i, bus.rob_dest_i,
                    bus.reg_dest_i);
        e.due = cyc + STAGES + 1;
        exp_q.push_back(e);
        if (e.misp) begin
          redir_due.push_back(e.due);
          redir_pc.push_back(e.npc);
        end
      end
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic drive_op(logic [15:0] op, logic [15:0] pc, logic [15:0] a, logic [15:0] b,
                          logic [2:0] cond, logic [3:0] fl, logic pt, logic [15:0] ptgt,
                          logic [3:0] rob, logic [4:0] rd);
    bus.opcode_i      = op;
    bus.pc_i          = pc;
    bus.operand1_i    = a;
    bus.operand2_i    = b;
    bus.cond_i        = cond;
    bus.flags_i       = fl;
    bus.pred_taken_i  = pt;
    bus.pred_target_i = ptgt;
    bus.rob_dest_i    = rob;
    bus.reg_dest_i    = rd;
  endtask

  task automatic drive_random_op();
    int          sel;
    logic [15:0] op;
    logic [15:0] pc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ptgt;
    sel = $urandom_range(0, 2);
    op  = (sel == 0) ? OP_BCC : ((sel == 1) ? OP_BL : OP_JR);
    pc  = 16'($urandom);
    a   = 16'($urandom);
    b   = 16'($urandom);
    if ($urandom_range(0, 1) == 1) ptgt = (sel == 0) ? pc + b : a;
    else                           ptgt = 16'($urandom);
    drive_op(op, pc, a, b, 3'($urandom), 4'($urandom), 1'($urandom), ptgt,
             4'($urandom), 5'($urandom));
  endtask

  task automatic settle();
    bus.in_v_i      = 1'b0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 40 && (exp_q.size() > 0 || redir_due.size() > 0); k++) tick();
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if (bus.out_v_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_v: got %b expected 0", bus.out_v_o);
    end
    checks++;
    if (bus.redirect_v_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_redirect_v: got %b expected 0", bus.redirect_v_o);
    end
    checks++;
    if (bus.redirect_pc_o !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_redirect_pc: got %h expected 0000", bus.redirect_pc_o);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready_o);
    end
    checks++;
    if (bus.out_v_o !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_out_v: got %b expected 0", bus.out_v_o);
    end
  endtask

  // One op through an idle unit: head and redirect must appear exactly STAGES+1 cycles later.
  task automatic test_single_op(string name, logic [15:0] op, logic [15:0] pc, logic [15:0] a,
                                logic [15:0] b, logic [2:0] cond, logic [3:0] fl, logic pt,
                                logic [15:0] ptgt, logic [3:0] rob, logic [4:0] rd,
                                logic x_taken, logic [15:0] x_npc, logic x_misp,
                                logic x_regw, logic [15:0] x_res);
    settle();
    bus.out_ready_i = 1'b0;
    drive_op(op, pc, a, b, cond, fl, pt, ptgt, rob, rd);
    bus.in_v_i = 1'b1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL %s in_ready: got %b expected 1", name, bus.in_ready_o);
    end
    tick();
    bus.in_v_i = 1'b0;
    for (int k = 1; k <= STAGES + 1; k++) begin
      checks++;
      if (bus.out_v_o !== (k == STAGES + 1)) begin
        errors++; $display("[TB] FAIL %s out_v cycle %0d: got %b expected %b", name, k, bus.out_v_o, (k == STAGES + 1));
      end
      checks++;
      if (bus.redirect_v_o !== (x_misp && (k == STAGES + 1))) begin
        errors++; $display("[TB] FAIL %s redirect_v cycle %0d: got %b expected %b", name, k, bus.redirect_v_o, (x_misp && (k == STAGES + 1)));
      end
      if (k == STAGES + 1) begin
        checks++;
        if ({bus.out_taken_o, bus.out_target_o, bus.out_mispredict_o, bus.out_reg_w_o,
             bus.out_rob_dest_o, bus.out_reg_dest_o} !== {x_taken, x_npc, x_misp, x_regw, rob, rd}) begin
          errors++;
          $display("[TB] FAIL %s head: got taken=%b target=%h misp=%b reg_w=%b rob=%0d rd=%0d expected taken=%b target=%h misp=%b reg_w=%b rob=%0d rd=%0d",
                   name, bus.out_taken_o, bus.out_target_o, bus.out_mispredict_o, bus.out_reg_w_o,
                   bus.out_rob_dest_o, bus.out_reg_dest_o, x_taken, x_npc, x_misp, x_regw, rob, rd);
        end
        if (op != OP_BCC) begin
          checks++;
          if (bus.out_result_o !== x_res) begin
            errors++; $display("[TB] FAIL %s result: got %h expected %h", name, bus.out_result_o, x_res);
          end
        end
        if (x_misp) begin
          checks++;
          if (bus.redirect_pc_o !== x_npc) begin
            errors++; $display("[TB] FAIL %s redirect_pc: got %h expected %h", name, bus.redirect_pc_o, x_npc);
          end
        end
      end
      tick();
    end
    checks++;
    if (bus.redirect_v_o !== 1'b0 || bus.out_v_o !== 1'b1) begin
      errors++; $display("[TB] FAIL %s hold: got redirect_v=%b out_v=%b expected 0 1", name, bus.redirect_v_o, bus.out_v_o);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    checks++;
    if (bus.out_v_o !== 1'b0) begin
      errors++; $display("[TB] FAIL %s pop: got out_v=%b expected 0", name, bus.out_v_o);
    end
  endtask

  task automatic test_backpressure();
    int accepts;
    int heads;
    settle();
    accepts = 0;
    heads   = 0;
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < FIFO_DEPTH + STAGES + 4; k++) begin
      drive_random_op();
      bus.in_v_i = 1'b1;
      compute_exp();
      checks++;
      if (bus.in_ready_o !== exp_in_ready) begin
        errors++; $display("[TB] FAIL bp_in_ready cycle %0d: got %b expected %b", k, bus.in_ready_o, exp_in_ready);
      end
      if (bus.in_ready_o === 1'b1) accepts++;
      tick();
    end
    bus.in_v_i = 1'b0;
    checks++;
    if (accepts != FIFO_DEPTH) begin
      errors++; $display("[TB] FAIL bp_accepts: got %0d expected %0d", accepts, FIFO_DEPTH);
    end
    checks++;
    if (bus.in_ready_o !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_full_in_ready: got %b expected 0", bus.in_ready_o);
    end
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < FIFO_DEPTH + 4; k++) begin
      compute_exp();
      checks++;
      if (bus.out_v_o !== exp_out_v) begin
        errors++; $display("[TB] FAIL bp_drain_out_v cycle %0d: got %b expected %b", k, bus.out_v_o, exp_out_v);
      end
      if (bus.out_v_o === 1'b1) heads++;
      if (exp_out_v) begin
        checks++;
        if ({bus.out_rob_dest_o, bus.out_reg_dest_o, bus.out_reg_w_o, bus.out_result_o,
             bus.out_taken_o, bus.out_target_o, bus.out_mispredict_o} !==
            {exp_head.rob, exp_head.rd, exp_head.reg_w, exp_head.result,
             exp_head.taken, exp_head.npc, exp_head.misp}) begin
          errors++;
          $display("[TB] FAIL bp_drain_head cycle %0d: got rob=%0d target=%h result=%h expected rob=%0d target=%h result=%h",
                   k, bus.out_rob_dest_o, bus.out_target_o, bus.out_result_o,
                   exp_head.rob, exp_head.npc, exp_head.result);
        end
      end
      tick();
    end
    checks++;
    if (heads != FIFO_DEPTH) begin
      errors++; $display("[TB] FAIL bp_drain_count: got %0d expected %0d", heads, FIFO_DEPTH);
    end
  endtask

  task automatic test_flush();
    settle();
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_op(OP_JR, 16'(16'h0100 + k), 16'(16'h0200 + k), 16'h0000, 3'd7, 4'h0,
               1'b0, 16'h0000, 4'(k + 1), 5'(k));
      bus.in_v_i = 1'b1;
      tick();
    end
    drive_op(OP_JR, 16'h0300, 16'h0400, 16'h0000, 3'd7, 4'h0, 1'b0, 16'h0000, 4'd15, 5'd31);
    bus.in_v_i  = 1'b1;
    bus.flush_i = 1'b1;
    tick();
    bus.in_v_i  = 1'b0;
    bus.flush_i = 1'b0;
    checks++;
    if (bus.out_v_o !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_out_v: got %b expected 0", bus.out_v_o);
    end
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_in_ready: got %b expected 1", bus.in_ready_o);
    end
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < STAGES + 6; k++) begin
      checks++;
      if (bus.out_v_o !== 1'b0 || bus.redirect_v_o !== 1'b0) begin
        errors++; $display("[TB] FAIL flush_quiet cycle %0d: got out_v=%b redirect_v=%b expected 0 0", k, bus.out_v_o, bus.redirect_v_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        drive_random_op();
        bus.in_v_i = 1'b1;
      end else begin
        bus.in_v_i = 1'b0;
      end
      bus.out_ready_i = ($urandom_range(0, 9) < 6);
      bus.flush_i     = ($urandom_range(0, 39) == 0);
      compute_exp();
      checks++;
      if (bus.in_ready_o !== exp_in_ready) begin
        errors++; $display("[TB] FAIL rnd_in_ready cycle %0d: got %b expected %b", k, bus.in_ready_o, exp_in_ready);
      end
      checks++;
      if (bus.out_v_o !== exp_out_v) begin
        errors++; $display("[TB] FAIL rnd_out_v cycle %0d: got %b expected %b", k, bus.out_v_o, exp_out_v);
      end
      checks++;
      if (bus.redirect_v_o !== exp_redir_v) begin
        errors++; $display("[TB] FAIL rnd_redirect_v cycle %0d: got %b expected %b", k, bus.redirect_v_o, exp_redir_v);
      end
      if (exp_redir_v) begin
        checks++;
        if (bus.redirect_pc_o !== exp_redir_pc) begin
          errors++; $display("[TB] FAIL rnd_redirect_pc cycle %0d: got %h expected %h", k, bus.redirect_pc_o, exp_redir_pc);
        end
      end
      if (exp_out_v) begin
        checks++;
        if ({bus.out_rob_dest_o, bus.out_reg_dest_o, bus.out_reg_w_o, bus.out_result_o,
             bus.out_taken_o, bus.out_target_o, bus.out_mispredict_o} !==
            {exp_head.rob, exp_head.rd, exp_head.reg_w, exp_head.result,
             exp_head.taken, exp_head.npc, exp_head.misp}) begin
          errors++;
          $display("[TB] FAIL rnd_head cycle %0d: got rob=%0d rd=%0d w=%b res=%h tk=%b tgt=%h mp=%b expected rob=%0d rd=%0d w=%b res=%h tk=%b tgt=%h mp=%b",
                   k, bus.out_rob_dest_o, bus.out_reg_dest_o, bus.out_reg_w_o, bus.out_result_o,
                   bus.out_taken_o, bus.out_target_o, bus.out_mispredict_o,
                   exp_head.rob, exp_head.rd, exp_head.reg_w, exp_head.result,
                   exp_head.taken, exp_head.npc, exp_head.misp);
        end
      end
      tick();
    end
    bus.flush_i = 1'b0;
    bus.in_v_i  = 1'b0;
  endtask

  // Reset in the middle of a cycle must clear queued results and a live redirect at once.
  task automatic test_reset_midop();
    settle();
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_op(OP_JR, 16'(16'h0500 + k), 16'h0600, 16'h0000, 3'd7, 4'h0, 1'b0,
               16'h0000, 4'(k + 8), 5'(k));
      bus.in_v_i = 1'b1;
      tick();
    end
    bus.in_v_i = 1'b0;
    tick();
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (bus.out_v_o !== 1'b0 || bus.redirect_v_o !== 1'b0) begin
      errors++; $display("[TB] FAIL midop_reset_outputs: got out_v=%b redirect_v=%b expected 0 0", bus.out_v_o, bus.redirect_v_o);
    end
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL midop_reset_in_ready: got %b expected 1", bus.in_ready_o);
    end
    exp_q.delete();
    redir_due.delete();
    redir_pc.delete();
    @(negedge clk_i);
    cyc++;
    reset_i = 1'b0;
    @(negedge clk_i);
    cyc++;
    checks++;
    if (bus.out_v_o !== 1'b0) begin
      errors++; $display("[TB] FAIL midop_after_release_out_v: got %b expected 0", bus.out_v_o);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    reset_i = 1'b1;
    bus.in_v_i      = 1'b0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    drive_op(16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 4'h0, 1'b0, 16'h0, 4'd0, 5'd0);
    $display("[TB] starting fu_branch_pipe bench");
    test_reset();
    test_single_op("bcc_eq_taken", OP_BCC, 16'h0010, 16'h0000, 16'hFFFC, 3'd0, 4'b0100, 1'b1,
                   16'h000C, 4'd1, 5'd0, 1'b1, 16'h000C, 1'b0, 1'b0, 16'h0000);
    test_single_op("bcc_lt_not_taken", OP_BCC, 16'h0020, 16'h0000, 16'h0000, 3'd2, 4'b1001, 1'b1,
                   16'h0000, 4'd2, 5'd0, 1'b0, 16'h0021, 1'b1, 1'b0, 16'h0000);
    test_single_op("bl_link", OP_BL, 16'h0030, 16'h0080, 16'h0000, 3'd0, 4'h0, 1'b1,
                   16'h0084, 4'd3, 5'd5, 1'b1, 16'h0080, 1'b1, 1'b1, 16'h0031);
    test_single_op("jr_mispredict", OP_JR, 16'h0040, 16'h1234, 16'h0000, 3'd0, 4'h0, 1'b0,
                   16'h0000, 4'd4, 5'd7, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000);
    test_single_op("wrap_al_taken", OP_BCC, 16'hFFFF, 16'h0000, 16'h0002, 3'd7, 4'h0, 1'b1,
                   16'h0001, 4'd5, 5'd0, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000);
    test_single_op("wrap_not_taken", OP_BCC, 16'hFFFF, 16'h0000, 16'h0000, 3'd0, 4'h0, 1'b0,
                   16'h0000, 4'd6, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    test_backpressure();
    test_flush();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
